// File: rtl/mem_read_arbiter_pkg.sv
// Shared types for the memory read arbiter.
//   mem_port_e    : requester identity, also the MSB of the outgoing AXI ID
//   mem_rd_req_t  : registered read request {addr, tid}
//   arb_state_e   : grant FSM states
// The struct layout uses the Def* widths; override the top-level widths
// together with these.
package mem_read_arbiter_pkg;

  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefTidWidth  = 4;
  localparam int unsigned DefMaxOutst  = 7;

  typedef enum logic {
    MEM_PORT_ICACHE = 1'b0,
    MEM_PORT_DCACHE = 1'b1
  } mem_port_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefTidWidth-1:0]  tid;
  } mem_rd_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  function automatic mem_port_e other_port(input mem_port_e p);
    return mem_port_e'(~p);
  endfunction

endpackage

// File: rtl/mem_read_arbiter_outst.sv
// outst_counter: outstanding-read counter for one requester.
//   clk_i, rst_i : clock, async active-high reset
//   inc_i        : request handshake for this port
//   dec_i        : last response beat for this port
//   full_o       : count == MaxOutst
//   empty_o      : count == 0
// Simultaneous inc/dec leaves the count unchanged; decrement at zero is
// illegal and saturates.
module outst_counter #(
  parameter int unsigned MaxOutst = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutst + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutst);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                cnt_q <= '0;
    else if (inc_i && !dec_i && !full_o)      cnt_q <= cnt_q + 1'b1;
    else if (dec_i && !inc_i && !empty_o)     cnt_q <= cnt_q - 1'b1;
  end

  assign full_o  = (cnt_q == CntMax);
  assign empty_o = (cnt_q == '0);

  // A last beat with nothing outstanding means the NoC returned a bogus ID.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && empty_o));

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI read channel between I-cache (port 0)
// and D-cache (port 1) refills.
//   clk_i/rst_i          : clock, async active-high reset
//   flush_i/flush_done_o : block new grants; one pulse once fully drained
//   req_*                : per-port request (valid/ready/addr/tid)
//   mem_*  (AR side)     : registered request, id = {port, tid}
//   mem_r* (R side)      : response beats, routed by rid MSB
//   rsp_*                : per-port valid, shared tid/data/last
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned TidWidth  = DefTidWidth,
  parameter int unsigned MaxOutst  = DefMaxOutst
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0][AddrWidth-1:0] req_addr_i,
  input  logic [1:0][TidWidth-1:0]  req_tid_i,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [TidWidth:0]         mem_id_o,
  input  logic                      mem_rvalid_i,
  input  logic [TidWidth:0]         mem_rid_i,
  input  logic [DataWidth-1:0]      mem_rdata_i,
  input  logic                      mem_rlast_i,
  output logic [1:0]                rsp_valid_o,
  output logic [TidWidth-1:0]       rsp_tid_o,
  output logic [DataWidth-1:0]      rsp_data_o,
  output logic                      rsp_last_o
);

  arb_state_e  state_q;
  mem_rd_req_t req_q;
  mem_port_e   gnt_q, rr_ptr_q, pick;
  logic        flush_seen_q;
  logic [1:0]  full, empty, elig, inc, dec;
  logic        hs, rsp_port, drain_ok;

  assign elig     = req_valid_i & ~full & {2{~flush_i}};
  assign hs       = (state_q == ST_HOLD) && mem_ready_i;
  assign rsp_port = mem_rid_i[TidWidth];

  // rr_ptr port wins when eligible, otherwise the other one.
  always_comb begin
    pick = rr_ptr_q;
    if (!elig[rr_ptr_q]) pick = other_port(rr_ptr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_valid_o <= 1'b0;
      req_q       <= '0;
      gnt_q       <= MEM_PORT_ICACHE;
      rr_ptr_q    <= MEM_PORT_ICACHE;
    end else begin
      case (state_q)
        ST_IDLE: if (|elig) begin
          req_q.addr  <= req_addr_i[pick];
          req_q.tid   <= req_tid_i[pick];
          gnt_q       <= pick;
          mem_valid_o <= 1'b1;
          state_q     <= ST_HOLD;
        end
        // Valid never drops before the handshake, even if flush_i rises.
        ST_HOLD: if (mem_ready_i) begin
          mem_valid_o <= 1'b0;
          rr_ptr_q    <= other_port(gnt_q);
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr_o = req_q.addr;
  assign mem_id_o   = {gnt_q, req_q.tid};

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign inc[p]         = hs && (gnt_q == mem_port_e'(p != 0));
    assign dec[p]         = mem_rvalid_i && mem_rlast_i && (rsp_port == (p != 0));
    assign rsp_valid_o[p] = mem_rvalid_i && (rsp_port == (p != 0));

    outst_counter #(.MaxOutst(MaxOutst)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc[p]),
      .dec_i   (dec[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );
  end

  // Ready is the handshake itself, steered to the granted port.
  assign req_ready_o = inc;

  assign rsp_tid_o  = mem_rid_i[TidWidth-1:0];
  assign rsp_data_o = mem_rdata_i;
  assign rsp_last_o = mem_rlast_i;

  // Drained: no request held and nothing outstanding on either port.
  assign drain_ok     = flush_i && (state_q == ST_IDLE) && (&empty);
  assign flush_done_o = drain_ok && !flush_seen_q && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         flush_seen_q <= 1'b0;
    else if (!flush_i) flush_seen_q <= 1'b0;
    else if (drain_ok) flush_seen_q <= 1'b1;
  end

endmodule
